// File: rtl/packet_order_scheduler.sv
// Arrival-order scheduler: one tag per packet selects which lane (compressor or bypass) owns the master for a whole packet.
// Data is a combinational pass-through; only the granted lane sees m_tready, the other stalls upstream; tag_ready drops when the tag queue is full.

module tag_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  output logic                     push_rdy,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  input  logic                     pop_rdy,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full check uses the registered count, so a same-cycle pop never frees a slot early.
  assign push_rdy = reset && (count != FULL_CNT);
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];
  assign do_push  = push_vld && push_rdy;
  assign do_pop   = pop_rdy && head_vld;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module packet_order_scheduler #(
  parameter int DATA_WIDTH = 256,
  parameter int TAG_DEPTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         tag_valid,
  input  logic                         tag_compressed,
  output logic                         tag_ready,
  input  logic [DATA_WIDTH-1:0]        comp_tdata,
  input  logic                         comp_tvalid,
  input  logic                         comp_tlast,
  output logic                         comp_tready,
  input  logic [DATA_WIDTH-1:0]        byp_tdata,
  input  logic                         byp_tvalid,
  input  logic                         byp_tlast,
  output logic                         byp_tready,
  output logic [DATA_WIDTH-1:0]        m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  output logic                         m_tsrc,
  input  logic                         m_tready,
  output logic [$clog2(TAG_DEPTH):0]   tag_count,
  output logic [CNT_WIDTH-1:0]         comp_pkt_cnt,
  output logic [CNT_WIDTH-1:0]         byp_pkt_cnt
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    BYP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   tag_pop;
  logic   tag_avail;
  logic   head_tag;
  logic   eop;

  tag_fifo #(
    .WIDTH (1),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (tag_valid),
    .push_dat (tag_compressed),
    .push_rdy (tag_ready),
    .head_vld (tag_avail),
    .head_dat (head_tag),
    .pop_rdy  (tag_pop),
    .count    (tag_count)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tag_pop     = 1'b0;
    m_tdata     = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tsrc      = 1'b0;
    comp_tready = 1'b0;
    byp_tready  = 1'b0;
    eop         = 1'b0;
    case (state)
      COMP: begin
        m_tdata     = comp_tdata;
        m_tvalid    = comp_tvalid;
        m_tlast     = comp_tlast;
        m_tsrc      = 1'b1;
        comp_tready = m_tready;
      end
      BYP: begin
        m_tdata    = byp_tdata;
        m_tvalid   = byp_tvalid;
        m_tlast    = byp_tlast;
        byp_tready = m_tready;
      end
      IDLE: begin
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) begin
      m_tvalid    = 1'b0;
      comp_tready = 1'b0;
      byp_tready  = 1'b0;
    end
    eop = (state != IDLE) && m_tvalid && m_tready && m_tlast;
    // Handoff at end of packet pops the next tag in the same cycle, so there is no bubble.
    if ((state == IDLE) || eop) begin
      if (tag_avail) begin
        tag_pop   = 1'b1;
        state_nxt = head_tag ? COMP : BYP;
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      comp_pkt_cnt <= '0;
      byp_pkt_cnt  <= '0;
    end else if (eop) begin
      if ((state == COMP) && (comp_pkt_cnt != '1)) begin
        comp_pkt_cnt <= comp_pkt_cnt + CNT_ONE;
      end
      if ((state == BYP) && (byp_pkt_cnt != '1)) begin
        byp_pkt_cnt <= byp_pkt_cnt + CNT_ONE;
      end
    end
  end

  a_one_lane_ready: assert property (@(posedge clk) disable iff (!reset)
    !(comp_tready && byp_tready));
  a_count_bound: assert property (@(posedge clk) disable iff (!reset)
    tag_count <= (AW+1)'(TAG_DEPTH));
endmodule

// File: tb/tb_packet_order_scheduler.sv
// Bench for packet_order_scheduler: vector table, directed ordering/handoff/backpressure/saturation sequences,
// then randomized traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_packet_order_scheduler;
  localparam int DW   = 64;
  localparam int TD   = 8;
  localparam int CW   = 4;
  localparam int AW   = $clog2(TD);
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          tag_valid = 1'b0;
  logic          tag_compressed = 1'b0;
  logic          tag_ready;
  logic [DW-1:0] comp_tdata = '0;
  logic          comp_tvalid = 1'b0;
  logic          comp_tlast = 1'b0;
  logic          comp_tready;
  logic [DW-1:0] byp_tdata = '0;
  logic          byp_tvalid = 1'b0;
  logic          byp_tlast = 1'b0;
  logic          byp_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tsrc;
  logic          m_tready = 1'b0;
  logic [AW:0]   tag_count;
  logic [CW-1:0] comp_pkt_cnt;
  logic [CW-1:0] byp_pkt_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  always #5 clk = ~clk;

  packet_order_scheduler #(
    .DATA_WIDTH (DW),
    .TAG_DEPTH  (TD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .tag_valid      (tag_valid),
    .tag_compressed (tag_compressed),
    .tag_ready      (tag_ready),
    .comp_tdata     (comp_tdata),
    .comp_tvalid    (comp_tvalid),
    .comp_tlast     (comp_tlast),
    .comp_tready    (comp_tready),
    .byp_tdata      (byp_tdata),
    .byp_tvalid     (byp_tvalid),
    .byp_tlast      (byp_tlast),
    .byp_tready     (byp_tready),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tsrc         (m_tsrc),
    .m_tready       (m_tready),
    .tag_count      (tag_count),
    .comp_pkt_cnt   (comp_pkt_cnt),
    .byp_pkt_cnt    (byp_pkt_cnt)
  );

  typedef struct {
    logic rst_n, tv, tc, cv, cl, bv, bl, mr;
    logic e_tr, e_ctr, e_btr, e_mv;
    int   e_cnt;
  } vec_t;

  typedef struct { logic [DW-1:0] dat; logic last; } lbeat_t;
  typedef struct { logic src; logic [DW-1:0] dat; logic last; int cyc; } obeat_t;

  lbeat_t cq[$];
  lbeat_t bq[$];
  obeat_t mon[$];
  logic   bfm_on = 1'b0;
  logic   gaps = 1'b0;
  logic   tag_acc = 1'b0;

  // Reference model: tag queue, current owner (0 none, 1 compressor, 2 bypass), packet counts.
  bit mq[$];
  int g = 0;
  int mcc = 0;
  int mbc = 0;
  bit model_valid = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc_n);
    end
  endtask

  task automatic model_check();
    logic rs, lv, ll;
    logic [DW-1:0] ld;
    rs = (reset === 1'b1);
    lv = (g == 1) ? comp_tvalid : (g == 2) ? byp_tvalid : 1'b0;
    ll = (g == 1) ? comp_tlast  : (g == 2) ? byp_tlast  : 1'b0;
    ld = (g == 1) ? comp_tdata  : (g == 2) ? byp_tdata  : '0;
    chk("tag_ready",   64'(tag_ready),   64'(rs && (mq.size() != TD)));
    chk("comp_tready", 64'(comp_tready), 64'(rs && (g == 1) && m_tready));
    chk("byp_tready",  64'(byp_tready),  64'(rs && (g == 2) && m_tready));
    chk("m_tvalid",    64'(m_tvalid),    64'(rs && lv));
    if (rs && model_valid) begin
      chk("m_tsrc",       64'(m_tsrc),       64'(g == 1));
      chk("m_tlast",      64'(m_tlast),      64'(ll));
      chk("m_tdata",      64'(m_tdata),      64'(ld));
      chk("tag_count",    64'(tag_count),    64'(mq.size()));
      chk("comp_pkt_cnt", 64'(comp_pkt_cnt), 64'(mcc));
      chk("byp_pkt_cnt",  64'(byp_pkt_cnt),  64'(mbc));
    end
  endtask

  task automatic model_update();
    logic lv, ll, eop, push;
    if (reset !== 1'b1) begin
      mq.delete();
      g = 0;
      mcc = 0;
      mbc = 0;
      model_valid = 1'b1;
      return;
    end
    lv = (g == 1) ? comp_tvalid : (g == 2) ? byp_tvalid : 1'b0;
    ll = (g == 1) ? comp_tlast  : (g == 2) ? byp_tlast  : 1'b0;
    eop = (g != 0) && lv && m_tready && ll;
    push = tag_valid && (mq.size() != TD);
    if (eop && g == 1) mcc = (mcc == CMAX) ? CMAX : mcc + 1;
    if (eop && g == 2) mbc = (mbc == CMAX) ? CMAX : mbc + 1;
    if (g == 0 || eop) g = (mq.size() == 0) ? 0 : (mq.pop_front() ? 1 : 2);
    if (push) mq.push_back(tag_compressed);
  endtask

  task automatic tick();
    logic cf, bf;
    obeat_t ob;
    #2;
    model_check();
    cf = comp_tvalid && comp_tready;
    bf = byp_tvalid && byp_tready;
    tag_acc = tag_valid && tag_ready;
    if (reset && m_tvalid && m_tready) begin
      ob.src = m_tsrc; ob.dat = m_tdata; ob.last = m_tlast; ob.cyc = cyc_n;
      mon.push_back(ob);
    end
    @(posedge clk);
    model_update();
    #1;
    cyc_n++;
    if (bfm_on) begin
      if (cf && cq.size() > 0) void'(cq.pop_front());
      if (bf && bq.size() > 0) void'(bq.pop_front());
      comp_tvalid = (cq.size() > 0) && !(gaps && ($urandom_range(3) == 0));
      comp_tdata  = (cq.size() > 0) ? cq[0].dat : '0;
      comp_tlast  = (cq.size() > 0) ? cq[0].last : 1'b0;
      byp_tvalid  = (bq.size() > 0) && !(gaps && ($urandom_range(3) == 0));
      byp_tdata   = (bq.size() > 0) ? bq[0].dat : '0;
      byp_tlast   = (bq.size() > 0) ? bq[0].last : 1'b0;
    end
  endtask

  task automatic push_tag(input logic t);
    tag_valid = 1'b1;
    tag_compressed = t;
    tick();
    tag_valid = 1'b0;
  endtask

  task automatic load(input logic lane, input int n, input logic [DW-1:0] base);
    lbeat_t b;
    for (int i = 0; i < n; i++) begin
      b.dat = base + DW'(i);
      b.last = (i == n - 1);
      if (lane) cq.push_back(b); else bq.push_back(b);
    end
  endtask

  task automatic run_until(input int n, input int budget, input string nm);
    int b;
    b = budget;
    while (mon.size() < n && b > 0) begin
      tick();
      b--;
    end
    chk(nm, 64'(mon.size()), 64'(n));
  endtask

  vec_t tbl[16];

  initial begin
    logic          es, el;
    logic [DW-1:0] ed;
    int            b;
    //            rst tv tc cv cl bv bl mr | tr ctr btr mv cnt
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, -1};
    tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,  0};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,  0};
    tbl[3]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b0,  1};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  1};
    tbl[5]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  2};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,  3};
    tbl[7]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  4};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  5};
    tbl[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  6};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  7};
    tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,  8};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b1,  8};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,  7};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b1,  7};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0,1'b0,  6};

    for (int i = 0; i < 16; i++) begin
      reset = tbl[i].rst_n; tag_valid = tbl[i].tv; tag_compressed = tbl[i].tc;
      comp_tvalid = tbl[i].cv; comp_tlast = tbl[i].cl; comp_tdata = {$urandom, $urandom};
      byp_tvalid = tbl[i].bv; byp_tlast = tbl[i].bl; byp_tdata = {$urandom, $urandom};
      m_tready = tbl[i].mr;
      #2;
      chk($sformatf("tbl%0d tag_ready", i),   64'(tag_ready),   64'(tbl[i].e_tr));
      chk($sformatf("tbl%0d comp_tready", i), 64'(comp_tready), 64'(tbl[i].e_ctr));
      chk($sformatf("tbl%0d byp_tready", i),  64'(byp_tready),  64'(tbl[i].e_btr));
      chk($sformatf("tbl%0d m_tvalid", i),    64'(m_tvalid),    64'(tbl[i].e_mv));
      if (tbl[i].e_cnt >= 0) chk($sformatf("tbl%0d tag_count", i), 64'(tag_count), 64'(tbl[i].e_cnt));
      tick();
    end

    // Reset with lanes quiet, then hand control of the lanes to the queue-driven sources.
    tag_valid = 1'b0; m_tready = 1'b1; reset = 1'b0;
    bfm_on = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("post-reset tag_count", 64'(tag_count), 64'(0));
    chk("post-reset comp_pkt_cnt", 64'(comp_pkt_cnt), 64'(0));
    chk("post-reset byp_pkt_cnt", 64'(byp_pkt_cnt), 64'(0));

    // Arrival order: bypass data waits behind the earlier compressor packet.
    mon.delete();
    load(1'b0, 3, 64'h100);
    push_tag(1'b1); push_tag(1'b0); push_tag(1'b1);
    load(1'b1, 4, 64'h0);
    load(1'b1, 2, 64'h200);
    run_until(9, 80, "order beats");
    for (int i = 0; i < 9 && i < mon.size(); i++) begin
      es = (i < 4) || (i >= 7);
      ed = (i < 4) ? DW'(i) : (i < 7) ? DW'(64'h100 + i - 4) : DW'(64'h200 + i - 7);
      el = (i == 3) || (i == 6) || (i == 8);
      chk($sformatf("order src[%0d]", i),  64'(mon[i].src),  64'(es));
      chk($sformatf("order data[%0d]", i), 64'(mon[i].dat),  64'(ed));
      chk($sformatf("order last[%0d]", i), 64'(mon[i].last), 64'(el));
    end
    tick();
    chk("order comp_pkt_cnt", 64'(comp_pkt_cnt), 64'(2));
    chk("order byp_pkt_cnt", 64'(byp_pkt_cnt), 64'(1));

    // Back-to-back single-beat packets: one beat every cycle across handoffs.
    for (int i = 0; i < 6; i++) push_tag(i % 2 == 0);
    mon.delete();
    load(1'b1, 1, 64'h10); load(1'b1, 1, 64'h11); load(1'b1, 1, 64'h12);
    load(1'b0, 1, 64'h20); load(1'b0, 1, 64'h21); load(1'b0, 1, 64'h22);
    run_until(6, 40, "b2b beats");
    if (mon.size() == 6) begin
      chk("b2b span", 64'(mon[5].cyc - mon[0].cyc), 64'(5));
      for (int i = 0; i < 6; i++) chk($sformatf("b2b src[%0d]", i), 64'(mon[i].src), 64'(i % 2 == 0));
    end

    // Backpressure toggling mid-packet: data 0..7 arrives once each, in order.
    push_tag(1'b1);
    mon.delete();
    load(1'b1, 8, 64'h0);
    b = 60;
    while (mon.size() < 8 && b > 0) begin
      m_tready = ~m_tready;
      tick();
      b--;
    end
    m_tready = 1'b1;
    chk("bp beats", 64'(mon.size()), 64'(8));
    for (int i = 0; i < 8 && i < mon.size(); i++) begin
      chk($sformatf("bp data[%0d]", i), 64'(mon[i].dat), 64'(i));
      chk($sformatf("bp last[%0d]", i), 64'(mon[i].last), 64'(i == 7));
    end

    // Counter saturation: 6 compressor packets so far, 8 more reach all-ones minus one, 3 more stick.
    for (int i = 0; i < 8; i++) push_tag(1'b1);
    mon.delete();
    for (int i = 0; i < 8; i++) load(1'b1, 1, 64'h300);
    run_until(8, 40, "sat beats a");
    tick();
    chk("sat comp_pkt_cnt near max", 64'(comp_pkt_cnt), 64'(CMAX - 1));
    for (int i = 0; i < 3; i++) push_tag(1'b1);
    mon.delete();
    for (int i = 0; i < 3; i++) load(1'b1, 1, 64'h400);
    run_until(3, 30, "sat beats b");
    tick();
    chk("sat comp_pkt_cnt stuck", 64'(comp_pkt_cnt), 64'(CMAX));
    chk("sat byp_pkt_cnt", 64'(byp_pkt_cnt), 64'(4));

    // Randomized traffic with valid gaps, backpressure and occasional resets.
    gaps = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      tag_valid = ($urandom_range(1) == 1);
      tag_compressed = ($urandom_range(1) == 1);
      m_tready = ($urandom_range(3) != 0);
      reset = ($urandom_range(499) != 0);
      tick();
      if (tag_acc) begin
        lbeat_t lb;
        int len;
        len = $urandom_range(1, 4);
        for (int k = 0; k < len; k++) begin
          lb.dat = {$urandom, $urandom};
          lb.last = (k == len - 1);
          if (tag_compressed) cq.push_back(lb); else bq.push_back(lb);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/packet_order_scheduler.md
Name: packet_order_scheduler

Overview:
- Output-side scheduler for the compression datapath.
- The ingress controller classifies each packet as compressible or bypass and posts a one-bit tag per packet, in arrival order.
- This block queues those tags and shares one AXI-stream master between the compressor output lane and the bypass lane. Whole packets are granted strictly in original arrival order, and per-lane packet counters are kept.

Parameters:
DATA_WIDTH, 256, width of all tdata buses
TAG_DEPTH, 8, tag FIFO entries (power of two, >=2)
CNT_WIDTH, 16, width of per-lane packet counters

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset
tag_valid  input  1  tag offered by ingress controller
tag_compressed  input  1  1 = packet routed to compressor lane, 0 = bypass lane
tag_ready  output  1  tag FIFO can accept
comp_tdata  input  DATA_WIDTH  compressor lane data
comp_tvalid  input  1  compressor lane valid
comp_tlast  input  1  compressor lane end of packet
comp_tready  output  1  compressor lane ready
byp_tdata  input  DATA_WIDTH  bypass lane data
byp_tvalid  input  1  bypass lane valid
byp_tlast  input  1  bypass lane end of packet
byp_tready  output  1  bypass lane ready
m_tdata  output  DATA_WIDTH  merged output data
m_tvalid  output  1  merged output valid
m_tlast  output  1  merged output end of packet
m_tsrc  output  1  1 = current beat from compressor lane
m_tready  input  1  downstream ready
tag_count  output  log2(TAG_DEPTH)+1  tag FIFO occupancy
comp_pkt_cnt  output  CNT_WIDTH  completed compressor-lane packets
byp_pkt_cnt  output  CNT_WIDTH  completed bypass-lane packets

Behaviour:
- Reset (reset==0 at a rising edge):
  - state=IDLE, FIFO pointers and tag_count=0, both counters=0.
  - While reset is low, tag_ready, comp_tready, byp_tready and m_tvalid are forced to 0 combinationally.
  - A packet in flight at reset is abandoned; its remaining beats are sent after reset only if a new tag grants that lane.
- Tag FIFO:
  - Push when tag_valid & tag_ready, with tag_ready = (tag_count != TAG_DEPTH).
  - When full, tag_ready stays 0 even if a pop occurs in the same cycle.
  - A pushed tag is poppable from the next cycle, so there is no same-cycle push-to-pop bypass.
  - Simultaneous push and pop leaves tag_count unchanged; pointers wrap modulo TAG_DEPTH.
- FSM states IDLE, COMP, BYP:
  - IDLE: if tag_count != 0, pop the head tag; next state is COMP if the tag is 1, else BYP. If empty, stay in IDLE.
  - COMP: m_tdata/m_tvalid/m_tlast = comp_*; comp_tready = m_tready; byp_tready = 0; m_tsrc = 1.
  - BYP: mirror of COMP using the byp_* lane; m_tsrc = 0.
  - End of packet is a beat with valid & m_tready & tlast on the granted lane.
  - At end of packet, the granted lane's counter increments. If tag_count != 0 in that cycle, the head tag is popped and the FSM goes directly to COMP or BYP with no bubble; otherwise it goes to IDLE.
- Outputs in IDLE: m_tvalid=0, m_tlast=0, m_tsrc=0, m_tdata=0, both lane treadys=0.
- The non-granted lane is never ready; its data stalls upstream untouched.
- Latency: combinational pass-through of data. Tag-to-first-beat takes one cycle from IDLE (pop cycle), or zero cycles on back-to-back handoff.
- Tag push at the same edge as the end-of-packet pop when the FIFO was empty: no handoff; the FSM goes to IDLE and the new tag is popped the following cycle.
- Counters saturate at all-ones and do not wrap.
- A beat with m_tready=0 holds the grant; tvalid dropping mid-packet holds the grant (no timeout).
- Single-beat packets (tlast on the first beat) are legal and counted.

Test Plan:
- Reset low for 2 cycles with random inputs -> all treadys and m_tvalid=0; after release, tag_count=0 and both counters=0.
- Tags 1,0,1 pushed; bypass lane offers a 3-beat packet first -> zero bypass beats forwarded until the 4-beat compressor packet completes. Output order is comp(4), byp(3), comp(n); m_tsrc follows 1,0,1; comp_pkt_cnt=2 and byp_pkt_cnt=1 at end.
- 8 tags pushed with no lane traffic -> tag_ready=0 after the 8th push, tag_count=8 (TAG_DEPTH=8). A 9th push attempted in the same cycle as a pop is refused.
- Back-to-back 1-beat packets with tags queued, m_tready=1 -> one output beat every cycle, no IDLE gap.
- m_tready toggled 0/1 mid-packet -> comp_tready mirrors m_tready; no beat lost or duplicated (check data sequence 0..7).
- Force comp_pkt_cnt to 0xFFFE via 2^16-2 packets (or a shortened CNT_WIDTH=2 build) -> counter sticks at all-ones after further packets.
